// File: rtl/dcache_snoop_bus.sv
// -----------------------------------------------------------------------------
// dcache_snoop_bus
//
// Snooping bus between two per-core Dcache controllers and main memory.
// One coherence transaction is in flight at a time:
//   * a request is arbitrated from the two Dcaches and broadcast for snooping;
//   * the fill comes from the peer cache (if it answers inside the snoop
//     window) or from a memory read;
//   * a GET_S answered by the peer also writes the line back to memory,
//     because the peer is downgrading M -> S;
//   * PUT_M writebacks go straight to memory and produce no fill.
//
// Build option:
//   DCACHE_BUS_RR_EN  defined   -> round-robin arbitration on simultaneous
//                                  requests (pointer flips to the non-winner
//                                  after every grant).
//                     undefined -> fixed priority, core 0 wins ties.
//
// Shared width macros (defaulted here when not supplied by the build):
//   DCACHE_TAG_W, DCACHE_IDX_W, DCACHE_WORD_IN_BITS
//
// Message encoding on *_message_* ports (2 bits):
//   0 = NONE, 1 = GET_S, 2 = GET_M, 3 = PUT_M
//
// Ports:
//   clk, rst                 clock (rising edge) and async active-low reset
//   dc_req_en_i[1:0]         per-core request valid, held until acked
//   dc_req_tag_i/idx_i       per-core request line address
//   dc_req_data_i            per-core writeback data (PUT_M)
//   dc_req_message_i         per-core request message
//   dc_rsp_vld_i/data_i      per-core snoop data response
//   bus_req_*_o              one-cycle broadcast of the granted request
//   bus_rsp_*_o              one-cycle fill to the requester
//   mem_req_*_o, mem_req_ack_i   memory command, held until acked
//   mem_rsp_vld_i/data_i     memory read data
// All outputs are registered.
// -----------------------------------------------------------------------------
`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 52
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 9
`endif
`ifndef DCACHE_WORD_IN_BITS
`define DCACHE_WORD_IN_BITS 64
`endif

module dcache_snoop_bus #(
  parameter int SNOOP_CYC = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [1:0]                                dc_req_en_i,
  input  logic [1:0][`DCACHE_TAG_W-1:0]             dc_req_tag_i,
  input  logic [1:0][`DCACHE_IDX_W-1:0]             dc_req_idx_i,
  input  logic [1:0][`DCACHE_WORD_IN_BITS-1:0]      dc_req_data_i,
  input  logic [1:0][1:0]                           dc_req_message_i,
  input  logic [1:0]                                dc_rsp_vld_i,
  input  logic [1:0][`DCACHE_WORD_IN_BITS-1:0]      dc_rsp_data_i,
  output logic                                      bus_req_ack_o,
  output logic                                      bus_req_id_o,
  output logic [`DCACHE_TAG_W-1:0]                  bus_req_tag_o,
  output logic [`DCACHE_IDX_W-1:0]                  bus_req_idx_o,
  output logic [1:0]                                bus_req_message_o,
  output logic                                      bus_rsp_vld_o,
  output logic                                      bus_rsp_id_o,
  output logic [`DCACHE_WORD_IN_BITS-1:0]           bus_rsp_data_o,
  output logic                                      mem_req_en_o,
  output logic                                      mem_req_wr_o,
  output logic [63:0]                               mem_req_addr_o,
  output logic [`DCACHE_WORD_IN_BITS-1:0]           mem_req_data_o,
  input  logic                                      mem_req_ack_i,
  input  logic                                      mem_rsp_vld_i,
  input  logic [`DCACHE_WORD_IN_BITS-1:0]           mem_rsp_data_i
);

  localparam int TAG_W  = `DCACHE_TAG_W;
  localparam int IDX_W  = `DCACHE_IDX_W;
  localparam int WORD_W = `DCACHE_WORD_IN_BITS;

  localparam logic [1:0] MSG_NONE  = 2'd0;
  localparam logic [1:0] MSG_GET_S = 2'd1;
  localparam logic [1:0] MSG_PUT_M = 2'd3;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BCAST    = 3'd1;
  localparam logic [2:0] S_SNOOP    = 3'd2;
  localparam logic [2:0] S_MEM_WR   = 3'd3;
  localparam logic [2:0] S_MEM_RD   = 3'd4;
  localparam logic [2:0] S_MEM_WAIT = 3'd5;
  localparam logic [2:0] S_RESP     = 3'd6;

  localparam logic [2:0] SNOOP_LAST = 3'(SNOOP_CYC - 1);

  // Transaction state
  logic [2:0]        state_r;
  logic [2:0]        cnt_r;
  logic              id_r;
  logic [TAG_W-1:0]  tag_r;
  logic [IDX_W-1:0]  idx_r;
  logic [1:0]        msg_r;
  logic [WORD_W-1:0] line_r;
  logic              wb_pend_r;

  logic [2:0]        state_next_s;
  logic [2:0]        cnt_next_s;
  logic              id_next_s;
  logic [TAG_W-1:0]  tag_next_s;
  logic [IDX_W-1:0]  idx_next_s;
  logic [1:0]        msg_next_s;
  logic [WORD_W-1:0] line_next_s;
  logic              wb_next_s;

  logic              winner_s;
  logic              peer_s;
  logic              peer_hit_s;

  // Next values of the registered outputs
  logic              ack_next_s;
  logic              req_id_next_s;
  logic [TAG_W-1:0]  req_tag_next_s;
  logic [IDX_W-1:0]  req_idx_next_s;
  logic [1:0]        req_msg_next_s;
  logic              rsp_vld_next_s;
  logic              rsp_id_next_s;
  logic [WORD_W-1:0] rsp_data_next_s;
  logic              mem_en_next_s;
  logic              mem_wr_next_s;
  logic [63:0]       mem_addr_next_s;
  logic [WORD_W-1:0] mem_data_next_s;

`ifdef DCACHE_BUS_RR_EN
  logic ptr_r;

  // Arbitration: on a tie the pointer names the winner
  always_comb begin
    if (dc_req_en_i == 2'b11) begin
      winner_s = ptr_r;
    end else begin
      winner_s = dc_req_en_i[1];
    end
  end

  // Round-robin pointer moves to the loser of every grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= 1'b0;
    end else if ((state_r == S_IDLE) && (|dc_req_en_i)) begin
      ptr_r <= ~winner_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Arbitration: core 0 wins whenever it is requesting
  always_comb begin
    if (dc_req_en_i[0]) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
  end
`endif

  // Only the non-requesting core may supply snoop data
  assign peer_s     = ~id_r;
  assign peer_hit_s = dc_rsp_vld_i[peer_s];

  // Next-state and transaction capture
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    id_next_s    = id_r;
    tag_next_s   = tag_r;
    idx_next_s   = idx_r;
    msg_next_s   = msg_r;
    line_next_s  = line_r;
    wb_next_s    = wb_pend_r;
    case (state_r)
      S_IDLE: begin
        if (|dc_req_en_i) begin
          state_next_s = S_BCAST;
          id_next_s    = winner_s;
          tag_next_s   = dc_req_tag_i[winner_s];
          idx_next_s   = dc_req_idx_i[winner_s];
          msg_next_s   = dc_req_message_i[winner_s];
          line_next_s  = dc_req_data_i[winner_s];
          wb_next_s    = 1'b0;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_BCAST: begin
        if (msg_r == MSG_PUT_M) begin
          state_next_s = S_MEM_WR;
        end else begin
          state_next_s = S_SNOOP;
          cnt_next_s   = 3'd0;
        end
      end
      S_SNOOP: begin
        // A peer answer on the last window cycle still counts as a hit
        if (peer_hit_s) begin
          line_next_s  = dc_rsp_data_i[peer_s];
          wb_next_s    = (msg_r == MSG_GET_S);
          state_next_s = S_RESP;
        end else if (cnt_r == SNOOP_LAST) begin
          state_next_s = S_MEM_RD;
        end else begin
          cnt_next_s   = cnt_r + 3'd1;
        end
      end
      S_MEM_RD: begin
        if (mem_req_ack_i) begin
          state_next_s = S_MEM_WAIT;
        end else begin
          state_next_s = S_MEM_RD;
        end
      end
      S_MEM_WAIT: begin
        if (mem_rsp_vld_i) begin
          line_next_s  = mem_rsp_data_i;
          state_next_s = S_RESP;
        end else begin
          state_next_s = S_MEM_WAIT;
        end
      end
      S_RESP: begin
        if (wb_pend_r) begin
          state_next_s = S_MEM_WR;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_MEM_WR: begin
        if (mem_req_ack_i) begin
          wb_next_s    = 1'b0;
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_MEM_WR;
        end
      end
      default: begin
        state_next_s = S_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so outputs can be registered
  always_comb begin
    ack_next_s      = 1'b0;
    req_id_next_s   = 1'b0;
    req_tag_next_s  = '0;
    req_idx_next_s  = '0;
    req_msg_next_s  = MSG_NONE;
    rsp_vld_next_s  = 1'b0;
    rsp_id_next_s   = 1'b0;
    rsp_data_next_s = '0;
    mem_data_next_s = '0;
    if (state_next_s == S_BCAST) begin
      ack_next_s     = 1'b1;
      req_id_next_s  = id_next_s;
      req_tag_next_s = tag_next_s;
      req_idx_next_s = idx_next_s;
      req_msg_next_s = msg_next_s;
    end else begin
      ack_next_s     = 1'b0;
    end
    if (state_next_s == S_RESP) begin
      rsp_vld_next_s  = 1'b1;
      rsp_id_next_s   = id_next_s;
      rsp_data_next_s = line_next_s;
    end else begin
      rsp_vld_next_s  = 1'b0;
    end
    mem_en_next_s   = (state_next_s == S_MEM_RD) || (state_next_s == S_MEM_WR);
    mem_wr_next_s   = (state_next_s == S_MEM_WR);
    if (mem_wr_next_s) begin
      mem_data_next_s = line_next_s;
    end else begin
      mem_data_next_s = '0;
    end
    mem_addr_next_s = 64'({tag_next_s, idx_next_s, 3'b000});
  end

  // Transaction state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      cnt_r     <= 3'd0;
      id_r      <= 1'b0;
      tag_r     <= '0;
      idx_r     <= '0;
      msg_r     <= MSG_NONE;
      line_r    <= '0;
      wb_pend_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      id_r      <= id_next_s;
      tag_r     <= tag_next_s;
      idx_r     <= idx_next_s;
      msg_r     <= msg_next_s;
      line_r    <= line_next_s;
      wb_pend_r <= wb_next_s;
    end
  end

  // Registered bus and memory outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_ack_o     <= 1'b0;
      bus_req_id_o      <= 1'b0;
      bus_req_tag_o     <= '0;
      bus_req_idx_o     <= '0;
      bus_req_message_o <= MSG_NONE;
      bus_rsp_vld_o     <= 1'b0;
      bus_rsp_id_o      <= 1'b0;
      bus_rsp_data_o    <= '0;
      mem_req_en_o      <= 1'b0;
      mem_req_wr_o      <= 1'b0;
      mem_req_addr_o    <= 64'd0;
      mem_req_data_o    <= '0;
    end else begin
      bus_req_ack_o     <= ack_next_s;
      bus_req_id_o      <= req_id_next_s;
      bus_req_tag_o     <= req_tag_next_s;
      bus_req_idx_o     <= req_idx_next_s;
      bus_req_message_o <= req_msg_next_s;
      bus_rsp_vld_o     <= rsp_vld_next_s;
      bus_rsp_id_o      <= rsp_id_next_s;
      bus_rsp_data_o    <= rsp_data_next_s;
      mem_req_en_o      <= mem_en_next_s;
      mem_req_wr_o      <= mem_wr_next_s;
      mem_req_addr_o    <= mem_addr_next_s;
      mem_req_data_o    <= mem_data_next_s;
    end
  end

endmodule

// File: tb/tb_dcache_snoop_bus.sv
// -----------------------------------------------------------------------------
// tb_dcache_snoop_bus
//
// Self-checking bench for dcache_snoop_bus. A transaction-level model predicts,
// from the requesters present, the snoop answer and the memory behaviour, the
// grant, the fill (cycle, target, data) and the memory commands; the bench
// plays cache peers and memory around the DUT cycle by cycle.
// -----------------------------------------------------------------------------
`ifndef DCACHE_TAG_W
`define DCACHE_TAG_W 52
`endif
`ifndef DCACHE_IDX_W
`define DCACHE_IDX_W 9
`endif
`ifndef DCACHE_WORD_IN_BITS
`define DCACHE_WORD_IN_BITS 64
`endif

module tb_dcache_snoop_bus;

  localparam int SC = 2;
  localparam int TW = `DCACHE_TAG_W;
  localparam int IW = `DCACHE_IDX_W;
  localparam int WW = `DCACHE_WORD_IN_BITS;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] GET_S = 2'd1;
  localparam logic [1:0] GET_M = 2'd2;
  localparam logic [1:0] PUT_M = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [1:0]             dc_req_en;
  logic [1:0][TW-1:0]     dc_req_tag;
  logic [1:0][IW-1:0]     dc_req_idx;
  logic [1:0][WW-1:0]     dc_req_data;
  logic [1:0][1:0]        dc_req_msg;
  logic [1:0]             dc_rsp_vld;
  logic [1:0][WW-1:0]     dc_rsp_data;
  logic                   bus_req_ack_o, bus_req_id_o, bus_rsp_vld_o, bus_rsp_id_o;
  logic [TW-1:0]          bus_req_tag_o;
  logic [IW-1:0]          bus_req_idx_o;
  logic [1:0]             bus_req_message_o;
  logic [WW-1:0]          bus_rsp_data_o, mem_req_data_o, mem_rsp_data;
  logic                   mem_req_en_o, mem_req_wr_o, mem_req_ack, mem_rsp_vld;
  logic [63:0]            mem_req_addr_o;

  dcache_snoop_bus #(.SNOOP_CYC(SC)) dut (
    .clk(clk), .rst(rst),
    .dc_req_en_i(dc_req_en), .dc_req_tag_i(dc_req_tag), .dc_req_idx_i(dc_req_idx),
    .dc_req_data_i(dc_req_data), .dc_req_message_i(dc_req_msg),
    .dc_rsp_vld_i(dc_rsp_vld), .dc_rsp_data_i(dc_rsp_data),
    .bus_req_ack_o(bus_req_ack_o), .bus_req_id_o(bus_req_id_o),
    .bus_req_tag_o(bus_req_tag_o), .bus_req_idx_o(bus_req_idx_o),
    .bus_req_message_o(bus_req_message_o),
    .bus_rsp_vld_o(bus_rsp_vld_o), .bus_rsp_id_o(bus_rsp_id_o), .bus_rsp_data_o(bus_rsp_data_o),
    .mem_req_en_o(mem_req_en_o), .mem_req_wr_o(mem_req_wr_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_ack_i(mem_req_ack), .mem_rsp_vld_i(mem_rsp_vld), .mem_rsp_data_i(mem_rsp_data)
  );

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;       // model of the round-robin pointer
  int last_grant = -1;
  int exp_grants[3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model arbitration: who should win given the set of requesters
  function automatic int pick(input logic [1:0] en);
`ifdef DCACHE_BUS_RR_EN
    if (en == 2'b11) return ptr_m;
    return en[1] ? 1 : 0;
`else
    return en[0] ? 0 : 1;
`endif
  endfunction

  task automatic raise(input int c, input logic [1:0] m, input logic [TW-1:0] t,
                       input logic [IW-1:0] x, input logic [WW-1:0] d);
    dc_req_en[c]   = 1'b1;
    dc_req_msg[c]  = m;
    dc_req_tag[c]  = t;
    dc_req_idx[c]  = x;
    dc_req_data[c] = d;
  endtask

  task automatic raise_rand(input int c, input logic [1:0] m);
    raise(c, m, TW'({$urandom(), $urandom()}), IW'($urandom()), WW'({$urandom(), $urandom()}));
  endtask

  task automatic clear_inputs();
    dc_rsp_vld  = 2'b00;
    mem_req_ack = 1'b0;
    mem_rsp_vld = 1'b0;
  endtask

  // One transaction. Entered at a negedge of a cycle in which the bus is idle.
  // peer_k: snoop cycle at which the peer answers (-1 = never; >= SC = too late).
  task automatic do_txn(input int peer_k, input logic [WW-1:0] peer_d,
                        input bit self_noise, input logic [WW-1:0] mem_d);
    int win, peer, ack_n, rsp_n, rd_n, wr_n, first_rd, fill_cyc, rsp_at, wait_n;
    bit hit, exp_rsp, exp_rd, exp_wr, in_cmd, done;
    logic [1:0] msg;
    logic [TW-1:0] tag_e;
    logic [IW-1:0] idx_e;
    logic [63:0] addr;
    logic [WW-1:0] fill_d, wr_d;
    win   = pick(dc_req_en);
    peer  = 1 - win;
    msg   = dc_req_msg[win];
    tag_e = dc_req_tag[win];
    idx_e = dc_req_idx[win];
    addr  = 64'({tag_e, idx_e, 3'b000});
    hit     = (msg != PUT_M) && (peer_k >= 0) && (peer_k < SC);
    exp_rsp = (msg != PUT_M);
    exp_rd  = exp_rsp && !hit;
    exp_wr  = (msg == PUT_M) || (msg == GET_S && hit);
    fill_d  = hit ? peer_d : mem_d;
    wr_d    = (msg == PUT_M) ? dc_req_data[win] : peer_d;
    fill_cyc = hit ? 3 + peer_k : -1;
`ifdef DCACHE_BUS_RR_EN
    ptr_m = peer;
`endif
    ack_n = 0; rsp_n = 0; rd_n = 0; wr_n = 0; first_rd = -1; rsp_at = -1;
    wait_n = 0; in_cmd = 1'b0; done = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      clear_inputs();
      if (cyc == 1) begin
        chk("ack_lat", 64'(bus_req_ack_o), 64'(1'b1));
        chk("ack_id", 64'(bus_req_id_o), 64'(win));
        chk("ack_tag", 64'(bus_req_tag_o), 64'(tag_e));
        chk("ack_idx", 64'(bus_req_idx_o), 64'(idx_e));
        chk("ack_msg", 64'(bus_req_message_o), 64'(msg));
        last_grant = int'(bus_req_id_o);
      end else begin
        chk("msg_none", 64'(bus_req_message_o), 64'(NONE));
      end
      if (bus_req_ack_o) begin
        ack_n++;
        dc_req_en[bus_req_id_o] = 1'b0;
      end
      if (self_noise && cyc >= 2 && cyc <= 1 + SC) begin
        dc_rsp_vld[win]  = 1'b1;
        dc_rsp_data[win] = WW'({$urandom(), $urandom()});
      end
      if (peer_k >= 0 && cyc == 2 + peer_k) begin
        dc_rsp_vld[peer]  = 1'b1;
        dc_rsp_data[peer] = peer_d;
      end
      if (bus_rsp_vld_o) begin
        rsp_n++;
        chk("fill_cyc", 64'(cyc), 64'(fill_cyc));
        chk("fill_id", 64'(bus_rsp_id_o), 64'(win));
        chk("fill_data", 64'(bus_rsp_data_o), 64'(fill_d));
        if (!exp_wr) done = 1'b1;
      end
      if (mem_req_en_o) begin
        if (!in_cmd) begin
          in_cmd = 1'b1;
          wait_n = $urandom_range(0, 2);
          if (!mem_req_wr_o && first_rd < 0) first_rd = cyc;
        end
        chk("mem_addr", mem_req_addr_o, addr);
        if (mem_req_wr_o) chk("mem_wdata", 64'(mem_req_data_o), 64'(wr_d));
        if (wait_n == 0) begin
          mem_req_ack = 1'b1;
          in_cmd = 1'b0;
          if (mem_req_wr_o) begin
            wr_n++;
            done = 1'b1;
          end else begin
            rd_n++;
            rsp_at = cyc + int'($urandom_range(1, 3));
          end
        end else begin
          wait_n--;
        end
      end
      if (cyc == rsp_at) begin
        mem_rsp_vld  = 1'b1;
        mem_rsp_data = mem_d;
        fill_cyc     = cyc + 1;
      end
    end
    chk("txn_done", 64'(done), 64'(1'b1));
    chk("ack_count", 64'(ack_n), 64'(1));
    chk("fill_count", 64'(rsp_n), 64'(exp_rsp));
    chk("rd_count", 64'(rd_n), 64'(exp_rd));
    chk("wr_count", 64'(wr_n), 64'(exp_wr));
    if (exp_rd) chk("rd_start", 64'(first_rd), 64'(2 + SC));
    // Bus must be back to idle in the following cycle
    @(negedge clk);
    clear_inputs();
    chk("post_mem_en", 64'(mem_req_en_o), 64'(1'b0));
    chk("post_fill", 64'(bus_rsp_vld_o), 64'(1'b0));
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ack"}, 64'(bus_req_ack_o), 64'(1'b0));
    chk({p, "_msg"}, 64'(bus_req_message_o), 64'(NONE));
    chk({p, "_fill"}, 64'(bus_rsp_vld_o), 64'(1'b0));
    chk({p, "_fdata"}, 64'(bus_rsp_data_o), 64'(1'b0));
    chk({p, "_men"}, 64'(mem_req_en_o), 64'(1'b0));
    chk({p, "_maddr"}, mem_req_addr_o, 64'd0);
    chk({p, "_mdata"}, 64'(mem_req_data_o), 64'(1'b0));
  endtask

  initial begin
    bit got;
    int pk;
    rst = 1'b0;
    dc_req_en = 2'b00; dc_req_tag = '0; dc_req_idx = '0; dc_req_data = '0;
    dc_req_msg = '0; dc_rsp_data = '0; mem_rsp_data = '0;
    clear_inputs();
`ifdef DCACHE_BUS_RR_EN
    exp_grants = '{0, 1, 0};
`else
    exp_grants = '{0, 0, 0};
`endif
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Core0 GET_M miss: tag 0x12, idx 3, memory returns 0xDEAD
    raise(0, GET_M, TW'(8'h12), IW'(4'h3), WW'(1'b0));
    do_txn(-1, WW'(1'b0), 1'b0, WW'(16'hDEAD));
    // Core1 GET_S, core0 answers 0xBEEF at snoop cycle 1 -> fill + writeback
    raise(1, GET_S, TW'(8'h34), IW'(4'h7), WW'(1'b0));
    do_txn(1, WW'(16'hBEEF), 1'b0, WW'(16'h1111));
    // Core0 PUT_M with data 0x55
    raise(0, PUT_M, TW'(8'h56), IW'(4'h9), WW'(8'h55));
    do_txn(-1, WW'(1'b0), 1'b0, WW'(1'b0));
    // Requester's own snoop valid must be ignored
    raise_rand(1, GET_M);
    do_txn(-1, WW'(1'b0), 1'b1, WW'(32'hCAFE_F00D));
    // Peer answer on the last window cycle still hits; one cycle later misses
    raise_rand(0, GET_M);
    do_txn(SC - 1, WW'(32'h0BAD_CAFE), 1'b0, WW'(16'h2222));
    raise_rand(1, GET_S);
    do_txn(SC, WW'(32'h0BAD_CAFE), 1'b0, WW'(16'h3333));

    // Simultaneous requests, the previous winner re-requests each round
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) if (!dc_req_en[c]) raise_rand(c, GET_M);
      do_txn(-1, WW'(1'b0), 1'b0, WW'({$urandom(), $urandom()}));
      chk("arb_grant", 64'(last_grant), 64'(exp_grants[r]));
    end
    while (|dc_req_en) do_txn(-1, WW'(1'b0), 1'b0, WW'({$urandom(), $urandom()}));

    // Reset while waiting for memory read data
    raise(0, GET_M, TW'(8'h77), IW'(4'h5), WW'(1'b0));
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      clear_inputs();
      if (bus_req_ack_o) dc_req_en[0] = 1'b0;
      if (mem_req_en_o) begin
        mem_req_ack = 1'b1;
        got = 1'b1;
      end
    end
    chk("rst_reach_rd", 64'(got), 64'(1'b1));
    @(negedge clk);
    clear_inputs();
    chk("wait_addr", mem_req_addr_o, 64'({TW'(8'h77), IW'(4'h5), 3'b000}));
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    #1 rst = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    mem_rsp_vld  = 1'b1;
    mem_rsp_data = WW'(16'h9999);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      chk("late_fill", 64'(bus_rsp_vld_o), 64'(1'b0));
      chk("late_men", 64'(mem_req_en_o), 64'(1'b0));
    end
    // Service resumes; a tie right after reset goes to core 0
    raise_rand(0, GET_M);
    raise_rand(1, GET_S);
    do_txn(0, WW'(16'h4444), 1'b0, WW'(16'h5555));
    chk("rst_grant", 64'(last_grant), 64'(0));
    while (|dc_req_en) do_txn(-1, WW'(1'b0), 1'b0, WW'(16'h6666));

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int c = 0; c < 2; c++)
        if (mask[c] && !dc_req_en[c]) raise_rand(c, 2'($urandom_range(1, 3)));
      pk = int'($urandom_range(0, SC + 1)) - 1;
      do_txn(pk, WW'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
             WW'({$urandom(), $urandom()}));
    end
    while (|dc_req_en) do_txn(-1, WW'(1'b0), 1'b0, WW'({$urandom(), $urandom()}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_snoop_bus.md
# dcache_snoop_bus

Two-core snooping bus between the per-core Dcache controllers and main memory. Arbitrates one coherence request at a time from the two Dcaches, broadcasts it to both for snooping, and sources the fill from the peer cache or from memory. Writebacks (PUT_M) go straight to memory. Sits directly downstream of each Dcache's bus request/response ports.

## Interface
Parameters:
- SNOOP_CYC, 2: cycles after broadcast during which a peer data response is accepted (1..7).
- `DCACHE_TAG_W`, `DCACHE_IDX_W`, `DCACHE_WORD_IN_BITS`: shared macros giving line tag, index and word widths.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dc_req_en_i[1:0]  in  2  per-core request valid; held until acked.
- dc_req_tag_i[c]  in  TAG_W  per-core request tag.
- dc_req_idx_i[c]  in  IDX_W  per-core request index.
- dc_req_data_i[c]  in  WORD  per-core writeback data, PUT_M only.
- dc_req_message_i[c]  in  message_t  GET_S / GET_M / PUT_M.
- dc_rsp_vld_i[1:0]  in  2  per-core snoop data response valid.
- dc_rsp_data_i[c]  in  WORD  per-core snoop data.
- bus_req_ack_o  out  1  broadcast pulse: request granted.
- bus_req_id_o  out  1  granted core id.
- bus_req_tag_o  out  TAG_W  broadcast tag.
- bus_req_idx_o  out  IDX_W  broadcast index.
- bus_req_message_o  out  message_t  broadcast message; NONE when idle.
- bus_rsp_vld_o  out  1  fill pulse to requester.
- bus_rsp_id_o  out  1  fill target core.
- bus_rsp_data_o  out  WORD  fill data.
- mem_req_en_o  out  1  memory command valid; held until mem_req_ack_i.
- mem_req_wr_o  out  1  1 = write, 0 = read.
- mem_req_addr_o  out  64  {tag, idx, 3'b000}.
- mem_req_data_o  out  WORD  write data.
- mem_req_ack_i  in  1  memory accepted command.
- mem_rsp_vld_i  in  1  read data valid.
- mem_rsp_data_i  in  WORD  read data.

## Operation
- FSM: IDLE, BCAST, SNOOP, MEM_WR, MEM_RD, MEM_WAIT, RESP.
- IDLE: if any dc_req_en_i, latch the winner's tag, idx, data, message and id, then go to BCAST.
- BCAST (1 cycle): drive bus_req_ack_o = 1 with the latched id, tag, idx and message. Next state:
  - PUT_M: MEM_WR.
  - Otherwise: SNOOP, snoop counter cleared.
- SNOOP: counter counts 0..SNOOP_CYC-1.
  - Only the non-requesting core's dc_rsp_vld_i is honoured; the requester's own rsp_vld is ignored.
  - Peer response: capture the data, then go to RESP.
  - GET_S with a peer response: also set a pending-writeback flag (the peer downgrades M→S, so memory is updated).
  - Window expires with no response: go to MEM_RD.
- MEM_RD: mem_req_en_o = 1, mem_req_wr_o = 0. On mem_req_ack_i go to MEM_WAIT.
- MEM_WAIT: on mem_rsp_vld_i capture the data, then go to RESP.
- RESP (1 cycle): bus_rsp_vld_o = 1 with the latched id and data.
  - Pending-writeback flag set: go to MEM_WR.
  - Otherwise: go to IDLE.
- MEM_WR: mem_req_en_o = 1, mem_req_wr_o = 1, data = captured line. On mem_req_ack_i clear the flag and go to IDLE. No bus_rsp for PUT_M.
- Only one transaction is outstanding. Requests arriving while busy stay pending; the requester holds req_en.
- Simultaneous requests are resolved by the Configuration rule below.
- mem_req_addr_o is always formed from the latched tag and idx.

## Timing
- Reset (rst low, any state, asynchronous):
  - FSM returns to IDLE and any in-flight transaction is dropped.
  - All *_o outputs = 0, bus_req_message_o = NONE.
  - Round-robin pointer = core 0.
- Request seen in IDLE at cycle N → bus_req_ack_o at N+1.
- Peer hit at snoop cycle k (k < SNOOP_CYC) → bus_rsp_vld_o at the cycle after the response.
- Miss: mem_req_en_o asserted at N+1+SNOOP_CYC+1. Fill appears 1 cycle after mem_rsp_vld_i.
- Outputs are registered; mem_req_en_o is held stable with unchanged fields until acked.
- A requester must deassert dc_req_en_i in the cycle after seeing ack with its id. A request still asserted in IDLE is treated as a new request.

## Configuration
- DCACHE_BUS_RR_EN defined: round-robin arbitration.
  - The pointer flips to the non-winner after each grant.
  - With simultaneous requests, the core the pointer names wins.
- Undefined: fixed priority, core 0 always wins simultaneous requests. The pointer logic is removed.

## Test plan
- Core0 GET_M, tag 0x12, idx 3, no peer response, SNOOP_CYC=2 → ack (id 0) at N+1; mem read addr {0x12,3,000}; memory returns 0xDEAD → bus_rsp_vld_o, id 0, data 0xDEAD.
- Core1 GET_S, core0 responds 0xBEEF at snoop cycle 1 → bus_rsp id 1, data 0xBEEF; then mem write of 0xBEEF to the same address; no mem read.
- Core0 PUT_M, data 0x55 → ack at N+1, mem write 0x55, no bus_rsp_vld_o, back to IDLE.
- Both cores request in the same cycle, three times with the RR macro defined → grants 0,1,0. Macro undefined → 0,0,0 while core0 keeps requesting.
- Requester drives its own dc_rsp_vld_i during SNOOP → ignored, memory read issued.
- rst asserted while in MEM_WAIT → all outputs 0 immediately; a late mem_rsp_vld_i produces no bus_rsp; the next request is serviced normally.
